// File: rtl/mem_bus_arbiter_if.sv
// Signal bundle between the CPU fetch/load-store ports, the bus arbiter and the
// external memory bus pins. The arbiter uses the slave view; requesters and the bus drive the master view.
interface mem_bus_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_rdata;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_done;
  logic [31:0] d_rdata;

  logic        busy;

  logic [31:0] ADDR;
  logic [31:0] Data_BUS_WRITE;
  logic [31:0] Data_BUS_READ;
  logic        CS;
  logic        WR_RD;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, Data_BUS_READ,
    output if_done, if_rdata, d_done, d_rdata, busy,
    output ADDR, Data_BUS_WRITE, CS, WR_RD
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, Data_BUS_READ,
    input  if_done, if_rdata, d_done, d_rdata, busy,
    input  ADDR, Data_BUS_WRITE, CS, WR_RD
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares the single external memory bus between instruction fetch and load/store
// using round-robin arbitration and a fixed-length bus cycle with WAIT_CYCLES extra CS cycles.
module mem_bus_arbiter #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic             CLK,
  input  logic             RST,
  mem_bus_arbiter_if.slave bus
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
  localparam logic       PORT_IF   = 1'b0;
  localparam logic       PORT_D    = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        gnt_q, gnt_d;
  logic        last_q, last_d;
  logic        store_q, store_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        cs_q, cs_d;
  logic        wr_rd_q, wr_rd_d;
  logic        busy_q, busy_d;
  logic        if_done_q, if_done_d;
  logic        d_done_q, d_done_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        pick_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    gnt_d      = gnt_q;
    last_d     = last_q;
    store_d    = store_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cs_d       = cs_q;
    wr_rd_d    = wr_rd_q;
    busy_d     = busy_q;
    if_done_d  = 1'b0;
    d_done_d   = 1'b0;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    pick_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.if_req || bus.d_req) begin
          // On a tie the port that did not win last time gets the bus.
          pick_d  = bus.d_req && (!bus.if_req || (last_q == PORT_IF));
          state_d = ACCESS;
          gnt_d   = pick_d;
          cnt_d   = WAIT_INIT;
          store_d = pick_d && bus.d_we;
          addr_d  = pick_d ? bus.d_addr : bus.if_addr;
          wdata_d = (pick_d && bus.d_we) ? bus.d_wdata : 32'h0;
          wr_rd_d = pick_d && bus.d_we;
          cs_d    = 1'b1;
          busy_d  = 1'b1;
        end
      end

      ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = DONE;
          cs_d    = 1'b0;
          wr_rd_d = 1'b0;
          if (gnt_q == PORT_D) begin
            d_done_d = 1'b1;
            if (!store_q) begin
              d_rdata_d = bus.Data_BUS_READ;
            end
          end else begin
            if_done_d  = 1'b1;
            if_rdata_d = bus.Data_BUS_READ;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        last_d  = gnt_q;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      gnt_q      <= PORT_IF;
      last_q     <= PORT_D;
      store_q    <= 1'b0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      cs_q       <= 1'b0;
      wr_rd_q    <= 1'b0;
      busy_q     <= 1'b0;
      if_done_q  <= 1'b0;
      d_done_q   <= 1'b0;
      if_rdata_q <= 32'h0;
      d_rdata_q  <= 32'h0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gnt_q      <= gnt_d;
      last_q     <= last_d;
      store_q    <= store_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cs_q       <= cs_d;
      wr_rd_q    <= wr_rd_d;
      busy_q     <= busy_d;
      if_done_q  <= if_done_d;
      d_done_q   <= d_done_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  // Every output comes straight from a flop.
  assign bus.ADDR           = addr_q;
  assign bus.Data_BUS_WRITE = wdata_q;
  assign bus.CS             = cs_q;
  assign bus.WR_RD          = wr_rd_q;
  assign bus.busy           = busy_q;
  assign bus.if_done        = if_done_q;
  assign bus.d_done         = d_done_q;
  assign bus.if_rdata       = if_rdata_q;
  assign bus.d_rdata        = d_rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: a WAIT_CYCLES=2 instance for the main tests
// and a WAIT_CYCLES=0 instance for back-to-back single-cycle accesses.
module tb_mem_bus_arbiter;
  localparam int W = 2;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  mem_bus_arbiter_if mb();
  mem_bus_arbiter_if mbz();

  mem_bus_arbiter #(.WAIT_CYCLES(W)) dut   (.CLK(CLK), .RST(RST), .bus(mb));
  mem_bus_arbiter #(.WAIT_CYCLES(0)) dut_z (.CLK(CLK), .RST(RST), .bus(mbz));

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (a == 32'h0000_0040) return 32'h2108_0001;
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_5A5A;
  endfunction

  assign mb.Data_BUS_READ  = mem_val(mb.ADDR);
  assign mbz.Data_BUS_READ = mem_val(mbz.ADDR);

  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  txn_t        sb[$];
  logic [31:0] zq[$];
  int          errors = 0;
  int          checks = 0;
  int          cs_cnt = 0;
  int          done_seen = 0;
  logic [31:0] exp_if_rdata = 32'h0;
  logic [31:0] exp_d_rdata = 32'h0;
  logic [31:0] z_addrs [3] = '{32'h0000_0080, 32'h0000_0084, 32'h0000_0088};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Bus monitor: every CS cycle and every done pulse is checked against the queue head.
  always @(negedge CLK) begin
    txn_t e;
    if (RST) begin
      sb.delete();
      cs_cnt = 0;
      exp_if_rdata = 32'h0;
      exp_d_rdata  = 32'h0;
    end else begin
      if (mb.CS) begin
        cs_cnt++;
        if (sb.size() == 0) begin
          check("cs_unexpected", 32'd1, 32'd0);
        end else begin
          check("bus_addr", mb.ADDR, sb[0].addr);
          check("bus_wr_rd", 32'(mb.WR_RD), 32'(sb[0].is_d && sb[0].we));
          check("bus_wdata", mb.Data_BUS_WRITE, (sb[0].is_d && sb[0].we) ? sb[0].wdata : 32'h0);
          check("busy_in_access", 32'(mb.busy), 32'd1);
        end
      end
      if (mb.if_done || mb.d_done) begin
        done_seen++;
        if (sb.size() == 0) begin
          check("done_unexpected", 32'({mb.if_done, mb.d_done}), 32'd0);
        end else begin
          e = sb.pop_front();
          check("done_port", 32'({mb.if_done, mb.d_done}), e.is_d ? 32'd1 : 32'd2);
          check("cs_cycles", cs_cnt, W + 1);
          if (e.is_d && !e.we) exp_d_rdata = mem_val(e.addr);
          if (!e.is_d) exp_if_rdata = mem_val(e.addr);
          check("if_rdata", mb.if_rdata, exp_if_rdata);
          check("d_rdata", mb.d_rdata, exp_d_rdata);
        end
        cs_cnt = 0;
      end
    end
  end

  task automatic single(input bit is_d, input bit we, input logic [31:0] a, input logic [31:0] wd,
                        input int chg_at, input logic [31:0] chg_a, output int lat);
    txn_t t;
    bit   seen;
    @(posedge CLK); #1;
    t.is_d = is_d; t.we = we; t.addr = a; t.wdata = wd;
    sb.push_back(t);
    if (is_d) begin
      mb.d_we = we; mb.d_addr = a; mb.d_wdata = wd; mb.d_req = 1'b1;
    end else begin
      mb.if_addr = a; mb.if_req = 1'b1;
    end
    lat  = 0;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(posedge CLK); #1;
      lat++;
      if (lat == chg_at) begin
        if (is_d) mb.d_addr = chg_a;
        else      mb.if_addr = chg_a;
      end
      seen = is_d ? mb.d_done : mb.if_done;
    end
    if (!seen) check("timeout_single", 32'd0, 32'd1);
    mb.if_req = 1'b0;
    mb.d_req  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat, base, n, cyc, cs_tot, last_done;
    txn_t t;
    mb.if_req = 1'b0;  mb.if_addr = 32'h0;  mb.d_req = 1'b0;  mb.d_we = 1'b0;
    mb.d_addr = 32'h0; mb.d_wdata = 32'h0;
    mbz.if_req = 1'b0; mbz.if_addr = 32'h0; mbz.d_req = 1'b0; mbz.d_we = 1'b0;
    mbz.d_addr = 32'h0; mbz.d_wdata = 32'h0;

    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    repeat (10) @(posedge CLK);
    #1;
    check("rst_cs", 32'(mb.CS), 32'd0);
    check("rst_wr_rd", 32'(mb.WR_RD), 32'd0);
    check("rst_busy", 32'(mb.busy), 32'd0);
    check("rst_addr", mb.ADDR, 32'h0);
    check("rst_wdata", mb.Data_BUS_WRITE, 32'h0);
    check("rst_if_done", 32'(mb.if_done), 32'd0);
    check("rst_d_done", 32'(mb.d_done), 32'd0);
    check("rst_if_rdata", mb.if_rdata, 32'h0);
    check("rst_d_rdata", mb.d_rdata, 32'h0);

    single(1'b0, 1'b0, 32'h0000_0040, 32'h0, -1, 32'h0, lat);
    check("if_latency", lat, W + 2);
    check("if_rdata_0x40", mb.if_rdata, 32'h2108_0001);

    single(1'b1, 1'b0, 32'h0000_0100, 32'h0, 2, 32'h0000_0200, lat);
    check("ld_latency", lat, W + 2);
    check("ld_rdata_0x100", mb.d_rdata, mem_val(32'h0000_0100));

    single(1'b1, 1'b1, 32'h1000_0004, 32'hDEAD_BEEF, -1, 32'h0, lat);
    check("st_latency", lat, W + 2);
    check("st_rdata_kept", mb.d_rdata, mem_val(32'h0000_0100));
    check("st_wr_rd_after", 32'(mb.WR_RD), 32'd0);

    // Tie from reset: fetch first, then strict alternation.
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    base = done_seen;
    for (int i = 0; i < 6; i++) begin
      t.is_d  = (i % 2) == 1;
      t.we    = 1'b0;
      t.addr  = t.is_d ? 32'h0000_0400 : 32'h0000_0300;
      t.wdata = 32'h0;
      sb.push_back(t);
    end
    mb.if_addr = 32'h0000_0300;
    mb.d_addr  = 32'h0000_0400;
    mb.d_we    = 1'b0;
    mb.if_req  = 1'b1;
    mb.d_req   = 1'b1;
    for (int c = 0; c < 60 && done_seen < base + 6; c++) begin
      @(posedge CLK); #1;
    end
    mb.if_req = 1'b0;
    mb.d_req  = 1'b0;
    check("alt_done_count", done_seen - base, 6);
    repeat (5) @(posedge CLK);
    #1;
    check("alt_no_extra", done_seen - base, 6);
    check("alt_sb_empty", sb.size(), 0);

    // Reset in the middle of an access.
    t.is_d = 1'b0; t.we = 1'b0; t.addr = 32'h0000_0500; t.wdata = 32'h0;
    sb.push_back(t);
    mb.if_addr = 32'h0000_0500;
    mb.if_req  = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    check("cs_before_rst", 32'(mb.CS), 32'd1);
    base = done_seen;
    RST = 1'b1;
    mb.if_req = 1'b0;
    @(posedge CLK);
    #1;
    check("midrst_cs", 32'(mb.CS), 32'd0);
    check("midrst_busy", 32'(mb.busy), 32'd0);
    check("midrst_if_done", 32'(mb.if_done), 32'd0);
    check("midrst_if_rdata", mb.if_rdata, 32'h0);
    check("midrst_d_rdata", mb.d_rdata, 32'h0);
    RST = 1'b0;
    repeat (6) @(posedge CLK);
    #1;
    check("midrst_no_done", done_seen - base, 0);

    // Zero-wait instance: back-to-back loads with d_req held high.
    n = 0; cyc = 0; cs_tot = 0; last_done = 0;
    mbz.d_we   = 1'b0;
    mbz.d_addr = z_addrs[0];
    zq.push_back(mem_val(z_addrs[0]));
    mbz.d_req  = 1'b1;
    for (int c = 0; c < 30 && n < 3; c++) begin
      @(posedge CLK); #1;
      cyc++;
      if (mbz.CS) cs_tot++;
      if (mbz.if_done) check("z_if_done", 32'd1, 32'd0);
      if (mbz.d_done) begin
        if (zq.size() > 0) check("z_rdata", mbz.d_rdata, zq.pop_front());
        else check("z_done_unexpected", 32'd1, 32'd0);
        if (n > 0) check("z_period", cyc - last_done, 3);
        last_done = cyc;
        n++;
        if (n < 3) begin
          mbz.d_addr = z_addrs[n];
          zq.push_back(mem_val(z_addrs[n]));
        end else begin
          mbz.d_req = 1'b0;
        end
      end
    end
    check("z_count", n, 3);
    check("z_cs_cycles", cs_tot, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Sequences and shares the CPU's single external memory bus (ADDR, Data_BUS_WRITE, Data_BUS_READ, CS, WR_RD) between the instruction-fetch port and the load/store data port. Each access is a fixed-length bus cycle with programmable wait states. Simultaneous requests are resolved round-robin. The block sits between the cpu core's fetch/memory stages and the external bus pins, clocked by the system clock domain.

## Interface
- WAIT_CYCLES, 2: extra cycles CS is held beyond the first access cycle; 0..15 legal.
- CLK  in  1  system clock, rising-edge.
- RST  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request, level; held until if_done.
- if_addr  in  32  fetch address, valid while if_req.
- if_done  out  1  one-cycle pulse: fetch complete, if_rdata valid.
- if_rdata  out  32  fetched word, registered.
- d_req  in  1  data request, level; held until d_done.
- d_we  in  1  1 = store, 0 = load; valid while d_req.
- d_addr  in  32  data address.
- d_wdata  in  32  store data.
- d_done  out  1  one-cycle pulse: data access complete.
- d_rdata  out  32  load data, registered; unchanged by stores.
- busy  out  1  high in ACCESS and DONE.
- ADDR  out  32  bus address.
- Data_BUS_WRITE  out  32  bus write data.
- Data_BUS_READ  in  32  bus read data.
- CS  out  1  bus chip select.
- WR_RD  out  1  1 = write, 0 = read; meaningful only while CS=1.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE: if no request, stay. If exactly one request is present, grant it. If both are present, grant the port not granted last; pointer `last` resets to "data", so fetch wins the first tie. On grant, latch addr/we/wdata into bus registers, load the wait counter with WAIT_CYCLES, and go to ACCESS.
- ACCESS: CS=1, ADDR = latched address.
  - WR_RD=1 only for a data store; fetch is always a read.
  - Data_BUS_WRITE = latched wdata for stores, 0 for reads.
  - Counter decrements each cycle. When it is 0, capture Data_BUS_READ into the granted port's rdata register (loads and fetches only) and go to DONE.
- DONE: CS=0, WR_RD=0, ADDR/Data_BUS_WRITE hold their values. The granted port's done=1 for this cycle only. Update `last` and go to IDLE unconditionally. Requests are not sampled in DONE.
- Requester inputs are sampled only at grant. Later changes during ACCESS have no effect.
- Reset values:
  - Outputs: CS=0, WR_RD=0, ADDR=0, Data_BUS_WRITE=0, if_done=0, d_done=0, if_rdata=0, d_rdata=0, busy=0.
  - State: IDLE, last=data.
- RST is dominant in every state. Reset mid-ACCESS drops CS at that edge, issues no done, and leaves both rdata registers at 0.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Request high at IDLE edge k gives:
  - ACCESS during cycles k+1 .. k+1+WAIT_CYCLES, so CS is high for WAIT_CYCLES+1 cycles.
  - DONE in cycle k+2+WAIT_CYCLES.
- Read data is sampled at the final ACCESS edge.
- Minimum request-to-request period per port is WAIT_CYCLES+3 cycles, including one IDLE cycle.
- A requester sees done at the edge ending DONE and may drop req on that same edge. A req still high in the following IDLE cycle is treated as a new request.
- With both ports continuously requesting, grants alternate fetch, data, fetch, and so on. Neither port waits more than one transaction.
- WAIT_CYCLES=0: exactly one ACCESS cycle.

## Test plan
- Reset, then idle 10 cycles → CS=0, busy=0, all outputs 0. Assert RST mid-ACCESS → CS=0 next cycle, no done pulse.
- Fetch only, if_addr=0x0000_0040, bus returns 0x2108_0001, WAIT_CYCLES=2 → CS high for 3 cycles, WR_RD=0, ADDR=0x40. if_done pulses 4 cycles after the request edge; if_rdata=0x2108_0001.
- Data store, d_addr=0x1000_0004, d_wdata=0xDEAD_BEEF → WR_RD=1 and Data_BUS_WRITE=0xDEAD_BEEF for all 3 CS cycles. d_done pulses once; d_rdata unchanged.
- if_req and d_req asserted on the same edge from reset → fetch granted first, data second. Held continuously, grants alternate for 6 transactions; no done ever pulses for the wrong port.
- Change d_addr mid-ACCESS from 0x100 to 0x200 → ADDR stays 0x100 for the whole transaction.
- WAIT_CYCLES=0 build, back-to-back loads → CS high 1 cycle per access, one request every 3 cycles.
